axil_led_regs: RTL and testbench
================================

# axil_led_regs

AXI4-Lite responder register bank that terminates the PCIe-to-AXI bridge master inside the `system` block design. It exposes an ID word, a scratch register, LED control and status counters to host software, and drives the board `led[7:0]` pins. It also carries the free-running LED counter, so the host can take over the LEDs from the default heartbeat display.

## Interface
- `ADDR_W`, 12: AXI address width. Decode uses `addr[ADDR_W-1:2]`; `addr[1:0]` is ignored.
- `ID_VALUE`, 32'hA71E_0001: constant returned at offset 0x00.
- `clk` in 1: single clock for all logic.
- `resetn` in 1: reset, asynchronous and active-low.
- `s_axil_awaddr` in ADDR_W, `s_axil_awvalid` in 1, `s_axil_awready` out 1: write address channel.
- `s_axil_wdata` in 32, `s_axil_wstrb` in 4, `s_axil_wvalid` in 1, `s_axil_wready` out 1: write data channel.
- `s_axil_bresp` out 2, `s_axil_bvalid` out 1, `s_axil_bready` in 1: write response channel.
- `s_axil_araddr` in ADDR_W, `s_axil_arvalid` in 1, `s_axil_arready` out 1: read address channel.
- `s_axil_rdata` out 32, `s_axil_rresp` out 2, `s_axil_rvalid` out 1, `s_axil_rready` in 1: read data channel.
- `led` out 8: registered LED drive.

## Operation
- Register map:
  - 0x00 ID: RO, `ID_VALUE`.
  - 0x04 SCRATCH: RW, reset 0.
  - 0x08 LED_CTRL: RW, reset 0. Bit0 = MODE (0 = counter, 1 = software). Bits 15:8 = SW_LED. All other bits read 0.
  - 0x0C FREE_COUNT: RO, 32-bit cycle counter.
  - 0x10 WR_COUNT: RO, 32-bit count of accepted writes to mapped offsets.
  - 0x14 DIMMER: see Configuration.
- Writes honour `wstrb` per byte. Writes to RO offsets are ignored and return OKAY.
- Any unmapped offset returns SLVERR (2'b10). Unmapped writes are ignored, do not count, and reads return 0. All other responses are OKAY (2'b00).
- FREE_COUNT increments every cycle from 0 after reset and wraps 0xFFFFFFFF→0.
- WR_COUNT increments once per accepted mapped write, including RO offsets, and wraps.
- LED source:
  - MODE=0: `led` = FREE_COUNT[31:24].
  - MODE=1: `led` = SW_LED.
- Write FSM states:
  - W_IDLE: `awready` = `wready` = 1 only when `awvalid` && `wvalid` are both high. AW and W are accepted in the same cycle, and whichever arrives first waits. Then go to W_RESP.
  - W_RESP: `bvalid` = 1, held stable until `bready`, then back to W_IDLE.
- Read FSM states:
  - R_IDLE: `arready` = 1 while `arvalid`. Then go to R_DATA.
  - R_DATA: `rvalid` = 1, `rdata`/`rresp` held stable until `rready`, then back to R_IDLE.
- Only one outstanding transaction per direction. The read and write paths are independent and may be active in the same cycle.
- Simultaneous read and write to the same offset in the same cycle: the read returns the pre-write value.

## Timing
- Reset values:
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0.
  - `bresp`, `rresp`, `rdata` = 0.
  - `led` = 0.
  - All registers at their reset values.
- Write accepted at edge N: register updated at N+1, `bvalid` high from N+1, `led` reflects the change at N+2.
- Read accepted at edge N: `rvalid`/`rdata` valid from N+1. FREE_COUNT is sampled at acceptance.
- `led` has one cycle of latency from its source (FREE_COUNT or SW_LED).
- Back-to-back throughput: one transaction every 2 cycles per direction, given zero-wait `bready`/`rready`.
- Reset asserted mid-transaction aborts it immediately. No response is issued after reset release.

## Configuration
- `AXIL_LED_REGS_DIMMER_EN` defined:
  - Offset 0x14 DIMMER is RW, bits 7:0 = DUTY, reset 8'hFF.
  - An 8-bit PWM counter free-runs from 0.
  - LED bits are gated on when `pwm_cnt < DUTY`, or always when DUTY = 0xFF. DUTY = 0 means fully off.
  - Gating is applied before the `led` register, so latency is unchanged.
- `AXIL_LED_REGS_DIMMER_EN` undefined:
  - 0x14 reads 0 with OKAY; writes are ignored but counted.
  - No PWM logic is present.

## Test plan
- Reset, then read 0x00 → `rdata` = 32'hA71E_0001, OKAY. Read 0x0C twice 10 cycles apart → difference of 10 + handshake cycles.
- Write 0x04 = 0xDEADBEEF with `wstrb` = 4'b0101, then read → 0x00AD00EF. WR_COUNT = 1.
- AW presented 3 cycles before W, with `bready` held low 4 cycles → a single acceptance cycle, `bvalid` stable until `bready`, one response only.
- Write 0x08 = 0x0000_A501 → `led` = 8'hA5 two cycles after acceptance. Write 0x08 = 0 → `led` tracks FREE_COUNT[31:24].
- Read 0x40 → SLVERR, `rdata` 0. Write 0x40 → SLVERR, WR_COUNT unchanged.
- With the macro defined: DUTY = 0x40 and MODE=1, SW_LED=0xFF → `led` = 0xFF for 64 of every 256 cycles. DUTY = 0 → `led` stays 0.

Source files
------------

// File: rtl/axil_led_regs.sv
`default_nettype none
// ============================================================================
// Module      : axil_led_regs
// Description : AXI4-Lite register bank with ID, scratch, LED control and
//               status counters. Drives the board LEDs from a free-running
//               heartbeat counter or from a software-written value.
// Optional    : define AXIL_LED_REGS_DIMMER_EN to add a DIMMER register at
//               0x14 and an 8-bit PWM that gates the LED outputs.
// Ports       : clk, resetn (async, active-low)
//               s_axil_aw* / s_axil_w* / s_axil_b*  : write channels
//               s_axil_ar* / s_axil_r*              : read channels
//               led[7:0]                            : registered LED drive
// Revision    : 1.0 - initial release
// ============================================================================
module axil_led_regs #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] ID_VALUE = 32'hA71E_0001
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [7:0]        led
);

  localparam int               IDX_W      = ADDR_W - 2;
  localparam logic [IDX_W-1:0] IDX_ID     = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_SCRATCH= IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_FREE   = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_WRCNT  = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_DIMMER = IDX_W'(5);
  localparam logic [1:0]       RESP_OKAY  = 2'b00;
  localparam logic [1:0]       RESP_SLVERR= 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t    w_state;
  r_state_t    r_state;

  logic [31:0] scratch;
  logic        mode;
  logic [7:0]  sw_led;
  logic [31:0] free_count;
  logic [31:0] wr_count;

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_fire;
  logic             rd_fire;
  logic             wr_mapped;
  logic             rd_mapped;
  logic [31:0]      rd_value;
  logic [7:0]       led_next;

  // Byte-lane select bits carry no information for word registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign wr_idx    = s_axil_awaddr[ADDR_W-1:2];
  assign rd_idx    = s_axil_araddr[ADDR_W-1:2];
  assign wr_mapped = (wr_idx <= IDX_DIMMER);
  assign rd_mapped = (rd_idx <= IDX_DIMMER);

  // AW and W are taken together; a lone channel waits for its partner.
  // Ready is held low during reset so nothing is acknowledged then.
  assign wr_fire        = resetn && (w_state == W_IDLE) && s_axil_awvalid && s_axil_wvalid;
  assign s_axil_awready = wr_fire;
  assign s_axil_wready  = wr_fire;

  assign rd_fire        = resetn && (r_state == R_IDLE) && s_axil_arvalid;
  assign s_axil_arready = rd_fire;

`ifdef AXIL_LED_REGS_DIMMER_EN
  logic [7:0] duty;
  logic [7:0] pwm_cnt;
  logic       pwm_on;

  assign pwm_on = (duty == 8'hFF) || (pwm_cnt < duty);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      duty    <= 8'hFF;
      pwm_cnt <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr_fire && (wr_idx == IDX_DIMMER) && s_axil_wstrb[0]) begin
        duty <= s_axil_wdata[7:0];
      end
    end
  end
`endif

  // Read mux uses current register contents, so a same-cycle write to the
  // same offset is not visible to the read.
  always_comb begin
    rd_value = 32'h0;
    case (rd_idx)
      IDX_ID:      rd_value = ID_VALUE;
      IDX_SCRATCH: rd_value = scratch;
      IDX_CTRL:    rd_value = {16'h0, sw_led, 7'h0, mode};
      IDX_FREE:    rd_value = free_count;
      IDX_WRCNT:   rd_value = wr_count;
`ifdef AXIL_LED_REGS_DIMMER_EN
      IDX_DIMMER:  rd_value = {24'h0, duty};
`endif
      default:     rd_value = 32'h0;
    endcase
  end

  always_comb begin
    led_next = mode ? sw_led : free_count[31:24];
`ifdef AXIL_LED_REGS_DIMMER_EN
    led_next = led_next & {8{pwm_on}};
`endif
  end

  // Register file and counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scratch    <= 32'h0;
      mode       <= 1'b0;
      sw_led     <= 8'h0;
      free_count <= 32'h0;
      wr_count   <= 32'h0;
      led        <= 8'h0;
    end else begin
      free_count <= free_count + 32'd1;
      led        <= led_next;
      if (wr_fire && wr_mapped) begin
        wr_count <= wr_count + 32'd1;
        if (wr_idx == IDX_SCRATCH) begin
          for (int b = 0; b < 4; b++) begin
            if (s_axil_wstrb[b]) scratch[8*b +: 8] <= s_axil_wdata[8*b +: 8];
          end
        end
        if (wr_idx == IDX_CTRL) begin
          if (s_axil_wstrb[0]) mode   <= s_axil_wdata[0];
          if (s_axil_wstrb[1]) sw_led <= s_axil_wdata[15:8];
        end
      end
    end
  end

  // Write response FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state       <= W_IDLE;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_fire) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            w_state       <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read data FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= R_IDLE;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= 32'h0;
      s_axil_rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_fire) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_value;
            s_axil_rresp  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_led_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_led_regs
// Description : Self-checking bench for axil_led_regs. A vector table drives
//               register reads/writes through a response scoreboard, then
//               hand-written sequences cover handshake, LED latency, same-
//               cycle read/write, reset abort and (optionally) the dimmer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_led_regs;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [11:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [7:0]  led;

  axil_led_regs #(.ADDR_W(12), .ID_VALUE(32'hA71E_0001)) dut (
    .clk(clk), .resetn(resetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready),
    .led(led)
  );

  always #5 clk = ~clk;

`ifdef AXIL_LED_REGS_DIMMER_EN
  localparam logic [31:0] DIM_RST = 32'h0000_00FF;
`else
  localparam logic [31:0] DIM_RST = 32'h0000_0000;
`endif
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int aw_acc = 0;
  int b_hs = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_axil_awvalid && s_axil_awready && s_axil_wvalid && s_axil_wready) aw_acc <= aw_acc + 1;
    if (s_axil_bvalid && s_axil_bready) b_hs <= b_hs + 1;
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t wq[$];
  exp_t rq[$];

  typedef struct {
    bit          is_wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  localparam int NV = 25;
  vec_t vec[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er);
    int n;
    exp_t e;
    e.data = '0;
    e.resp = er;
    wq.push_back(e);
    @(negedge clk);
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
    #1;
    n = 0;
    while (!(s_axil_awready && s_axil_wready) && n < 20) begin @(negedge clk); #1; n++; end
    if (!(s_axil_awready && s_axil_wready)) begin
      timeout($sformatf("wr_accept_%h", a));
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      void'(wq.pop_back());
      return;
    end
    @(posedge clk);
    #1 s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!s_axil_bvalid && n < 20) begin @(negedge clk); n++; end
    e = wq.pop_front();
    if (!s_axil_bvalid) timeout($sformatf("bvalid_%h", a));
    else check($sformatf("bresp_%h", a), 32'(s_axil_bresp), 32'(e.resp));
  endtask

  task automatic read_raw(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int acc);
    int n;
    d = 'x; r = 'x; acc = 0;
    @(negedge clk);
    s_axil_araddr = a; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    #1;
    n = 0;
    while (!s_axil_arready && n < 20) begin @(negedge clk); #1; n++; end
    if (!s_axil_arready) begin
      timeout($sformatf("rd_accept_%h", a));
      s_axil_arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 s_axil_arvalid = 1'b0;
    acc = cyc;
    @(negedge clk);
    n = 0;
    while (!s_axil_rvalid && n < 20) begin @(negedge clk); n++; end
    if (!s_axil_rvalid) begin timeout($sformatf("rvalid_%h", a)); return; end
    d = s_axil_rdata; r = s_axil_rresp;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er);
    logic [31:0] d;
    logic [1:0]  r;
    int          acc;
    exp_t        e;
    e.data = ed; e.resp = er;
    rq.push_back(e);
    read_raw(a, d, r, acc);
    e = rq.pop_front();
    check($sformatf("rdata_%h", a), d, e.data);
    check($sformatf("rresp_%h", a), 32'(r), 32'(e.resp));
  endtask

  initial begin
    logic [31:0] v1, v2;
    logic [1:0]  r1, r2;
    int          a1, a2, bad, cnt, aw0, b0;

    vec[0]  = '{0, 12'h000, 32'h0,        4'h0, 32'hA71E_0001, OK};
    vec[1]  = '{1, 12'h004, 32'hDEADBEEF, 4'h5, 32'h0,         OK};
    vec[2]  = '{0, 12'h004, 32'h0,        4'h0, 32'h00AD_00EF, OK};
    vec[3]  = '{0, 12'h010, 32'h0,        4'h0, 32'd1,         OK};
    vec[4]  = '{1, 12'h004, 32'h12345678, 4'hF, 32'h0,         OK};
    vec[5]  = '{0, 12'h004, 32'h0,        4'h0, 32'h1234_5678, OK};
    vec[6]  = '{1, 12'h000, 32'hFFFFFFFF, 4'hF, 32'h0,         OK};
    vec[7]  = '{0, 12'h000, 32'h0,        4'h0, 32'hA71E_0001, OK};
    vec[8]  = '{1, 12'h00C, 32'h0,        4'hF, 32'h0,         OK};
    vec[9]  = '{0, 12'h010, 32'h0,        4'h0, 32'd4,         OK};
    vec[10] = '{0, 12'h040, 32'h0,        4'h0, 32'h0,         SE};
    vec[11] = '{1, 12'h040, 32'hFFFFFFFF, 4'hF, 32'h0,         SE};
    vec[12] = '{0, 12'h010, 32'h0,        4'h0, 32'd4,         OK};
    vec[13] = '{1, 12'h008, 32'hFFFFFFFF, 4'hF, 32'h0,         OK};
    vec[14] = '{0, 12'h008, 32'h0,        4'h0, 32'h0000_FF01, OK};
    vec[15] = '{1, 12'h008, 32'h0000A500, 4'h2, 32'h0,         OK};
    vec[16] = '{0, 12'h008, 32'h0,        4'h0, 32'h0000_A501, OK};
    vec[17] = '{1, 12'h014, 32'h0,        4'h0, 32'h0,         OK};
    vec[18] = '{0, 12'h014, 32'h0,        4'h0, DIM_RST,       OK};
    vec[19] = '{0, 12'h010, 32'h0,        4'h0, 32'd7,         OK};
    vec[20] = '{0, 12'h018, 32'h0,        4'h0, 32'h0,         SE};
    vec[21] = '{0, 12'hFFC, 32'h0,        4'h0, 32'h0,         SE};
    vec[22] = '{0, 12'h007, 32'h0,        4'h0, 32'h1234_5678, OK};
    vec[23] = '{1, 12'h406, 32'hFFFFFFFF, 4'hF, 32'h0,         SE};
    vec[24] = '{0, 12'h010, 32'h0,        4'h0, 32'd7,         OK};

    // Reset state, checked while reset is held.
    #12;
    check("rst_awready", 32'(s_axil_awready), 32'd0);
    check("rst_arready", 32'(s_axil_arready), 32'd0);
    check("rst_bvalid",  32'(s_axil_bvalid),  32'd0);
    check("rst_rvalid",  32'(s_axil_rvalid),  32'd0);
    check("rst_bresp_rresp", 32'({s_axil_bresp, s_axil_rresp}), 32'd0);
    check("rst_rdata",   s_axil_rdata, 32'h0);
    check("rst_led",     32'(led), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (vec[i].is_wr) do_write(vec[i].addr, vec[i].data, vec[i].strb, vec[i].exp_resp);
      else              do_read(vec[i].addr, vec[i].exp_data, vec[i].exp_resp);
    end

    // FREE_COUNT advances by exactly the cycles between read acceptances.
    read_raw(12'h00C, v1, r1, a1);
    repeat (10) @(negedge clk);
    read_raw(12'h00C, v2, r2, a2);
    check("free_count_delta", v2 - v1, 32'(a2 - a1));
    check("free_count_gap_gt10", 32'((v2 - v1) > 32'd10), 32'd1);

    // AW leads W by 3 cycles, bready held low for 4 cycles.
    aw0 = aw_acc; b0 = b_hs; bad = 0;
    @(negedge clk);
    s_axil_awaddr = 12'h004; s_axil_awvalid = 1'b1; s_axil_bready = 1'b0;
    s_axil_wdata = 32'hCAFEF00D; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b0;
    repeat (3) begin #1; if (s_axil_awready || s_axil_wready) bad++; @(negedge clk); end
    check("aw_waits_for_w", 32'(bad), 32'd0);
    s_axil_wvalid = 1'b1;
    #1 check("aw_w_ready", 32'({s_axil_awready, s_axil_wready}), 32'd3);
    @(posedge clk);
    #1 s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    bad = 0;
    repeat (4) begin @(negedge clk); if (!s_axil_bvalid || s_axil_bresp !== OK) bad++; end
    check("bvalid_held", 32'(bad), 32'd0);
    s_axil_bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bvalid_dropped", 32'(s_axil_bvalid), 32'd0);
    check("single_accept", 32'(aw_acc - aw0), 32'd1);
    check("single_response", 32'(b_hs - b0), 32'd1);
    do_read(12'h004, 32'hCAFEF00D, OK);

    // LED latency: software value appears one cycle after the register.
    do_write(12'h008, 32'h0000_3C01, 4'hF, OK);
    repeat (2) @(negedge clk);
    check("led_3c", 32'(led), 32'h3C);
    do_write(12'h008, 32'h0000_A501, 4'hF, OK);
    check("led_old_at_n1", 32'(led), 32'h3C);
    @(negedge clk);
    check("led_a5_at_n2", 32'(led), 32'hA5);
    do_write(12'h008, 32'h0, 4'hF, OK);
    repeat (2) @(negedge clk);
    read_raw(12'h00C, v1, r1, a1);
    check("led_counter_mode", 32'(led), 32'(v1[31:24]));

    // Same-cycle read and write to SCRATCH: read sees the old value.
    @(negedge clk);
    s_axil_awaddr = 12'h004; s_axil_wdata = 32'h1111_2222; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
    s_axil_araddr = 12'h004; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    @(posedge clk);
    #1 s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    @(negedge clk);
    check("rw_same_rvalid_bvalid", 32'({s_axil_rvalid, s_axil_bvalid}), 32'd3);
    check("rw_same_old_value", s_axil_rdata, 32'hCAFEF00D);
    do_read(12'h004, 32'h1111_2222, OK);
    do_read(12'h010, 32'd12, OK);

`ifdef AXIL_LED_REGS_DIMMER_EN
    do_write(12'h014, 32'h40, 4'h1, OK);
    do_write(12'h008, 32'h0000_FF01, 4'hF, OK);
    repeat (3) @(negedge clk);
    cnt = 0; bad = 0;
    repeat (256) begin
      @(negedge clk);
      if (led == 8'hFF) cnt++;
      else if (led != 8'h00) bad++;
    end
    check("pwm_on_cycles", 32'(cnt), 32'd64);
    check("pwm_levels", 32'(bad), 32'd0);
    do_write(12'h014, 32'h0, 4'h1, OK);
    repeat (3) @(negedge clk);
    cnt = 0;
    repeat (256) begin @(negedge clk); if (led != 8'h00) cnt++; end
    check("pwm_duty0_off", 32'(cnt), 32'd0);
    do_read(12'h014, 32'h0, OK);
`endif

    // Reset in the middle of outstanding read and write responses.
    @(negedge clk);
    s_axil_araddr = 12'h004; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    s_axil_awaddr = 12'h004; s_axil_wdata = 32'h5555_AAAA; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b0;
    @(posedge clk);
    #1 s_axil_arvalid = 1'b0; s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    @(negedge clk);
    check("pre_reset_pending", 32'({s_axil_rvalid, s_axil_bvalid}), 32'd3);
    #2 resetn = 1'b0;
    #1 check("async_reset_abort", 32'({s_axil_rvalid, s_axil_bvalid}), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    repeat (5) begin @(negedge clk); if (s_axil_rvalid || s_axil_bvalid) bad++; end
    check("no_response_after_reset", 32'(bad), 32'd0);
    do_read(12'h004, 32'h0, OK);
    do_read(12'h010, 32'h0, OK);
    do_read(12'h008, 32'h0, OK);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
